// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: 1-cycle little-endian word fetch from a byte store
// that a byte-serial loader fills. Optional macro INSTR_ALIGN_CHECK_EN rejects unaligned fetches.
module instr_mem_responder #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic              instr_misalign,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    LOADING = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              instr_valid_q, instr_valid_d;
  logic [31:0]       instr_q, instr_d;
  logic              misalign_q, misalign_d;
  logic              ld_done_q, ld_done_d;
  logic              mem_we;

  logic [7:0]        mem_q [DEPTH];

  // Word read wraps around the top of the store.
  logic [ADDR_W-1:0] rd_a1, rd_a2, rd_a3;
  logic [31:0]       rd_word;
  assign rd_a1   = fetch_addr + ADDR_W'(1);
  assign rd_a2   = fetch_addr + ADDR_W'(2);
  assign rd_a3   = fetch_addr + ADDR_W'(3);
  assign rd_word = {mem_q[rd_a3], mem_q[rd_a2], mem_q[rd_a1], mem_q[fetch_addr]};

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    ptr_d         = ptr_q;
    count_d       = count_q;
    instr_valid_d = 1'b0;
    instr_d       = instr_q;
    misalign_d    = misalign_q;
    ld_done_d     = 1'b0;
    mem_we        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ld_start) begin
          state_d = LOADING;
          ptr_d   = '0;
          count_d = '0;
        end else if (fetch_req) begin
          instr_valid_d = 1'b1;
`ifdef INSTR_ALIGN_CHECK_EN
          if (fetch_addr[1:0] != 2'b00) begin
            instr_d    = NOP_INSTR;
            misalign_d = 1'b1;
          end else begin
            instr_d    = rd_word;
            misalign_d = 1'b0;
          end
`else
          instr_d    = rd_word;
          misalign_d = 1'b0;
`endif
        end
      end
      LOADING: begin
        if (ld_start) begin
          ptr_d   = '0;
          count_d = '0;
        end else if (ld_valid) begin
          mem_we  = 1'b1;
          ptr_d   = ptr_q + ADDR_W'(1);
          count_d = count_q + (ADDR_W+1)'(1);
          if (ld_last || count_q == LAST_COUNT) begin
            state_d   = IDLE;
            ld_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      count_q       <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      misalign_q    <= 1'b0;
      ld_done_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      count_q       <= count_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      misalign_q    <= misalign_d;
      ld_done_q     <= ld_done_d;
    end
  end

  // NOTE: the byte store has no reset; loaded contents must survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[ptr_q] <= ld_byte;
  end

  assign fetch_ready = (state_q == IDLE);
  assign ld_ready    = (state_q == LOADING);
  assign ld_busy     = (state_q == LOADING);
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign ld_done     = ld_done_q;
  assign ld_count    = count_q;
`ifdef INSTR_ALIGN_CHECK_EN
  assign instr_misalign = misalign_q;
`else
  assign instr_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench for instr_mem_responder: directed vectors, corner sequences,
// and randomized loads/fetches against a byte-array reference model.
module tb_instr_mem_responder;

  localparam int DEPTH = 1024;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [9:0]  fetch_addr;
  logic        fetch_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_misalign;
  logic        ld_start, ld_valid, ld_last;
  logic [7:0]  ld_byte;
  logic        ld_ready, ld_busy, ld_done;
  logic [10:0] ld_count;

  instr_mem_responder dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .instr_valid(instr_valid), .instr(instr), .instr_misalign(instr_misalign),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done), .ld_count(ld_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] mem_m [DEPTH];

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] instr;
    logic        misalign;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_req = 1'b0; fetch_addr = '0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;
  endtask

  function automatic logic [31:0] model_word(input int a);
`ifdef INSTR_ALIGN_CHECK_EN
    if (a % 4 != 0) return NOP;
`endif
    return {mem_m[(a+3)%DEPTH], mem_m[(a+2)%DEPTH], mem_m[(a+1)%DEPTH], mem_m[a%DEPTH]};
  endfunction

  function automatic logic model_misalign(input int a);
`ifdef INSTR_ALIGN_CHECK_EN
    return (a % 4 != 0);
`else
    return (a < 0);
`endif
  endfunction

  task automatic fetch_one(input int a, input string name);
    fetch_req = 1'b1; fetch_addr = 10'(a);
    tick();
    fetch_req = 1'b0;
    check({name, " valid"}, instr_valid, 1);
    check({name, " instr"}, instr, model_word(a));
    check({name, " misalign"}, instr_misalign, model_misalign(a));
  endtask

  // Load a byte list from pointer 0, ld_last on the final byte.
  task automatic load_bytes(input logic [7:0] b [], input bit gaps);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("load busy", ld_busy, 1);
    for (int i = 0; i < b.size(); i++) begin
      while (gaps && $urandom_range(0, 2) == 0) begin
        ld_valid = 1'b0; ld_byte = 8'($urandom); ld_last = 1'($urandom);
        fetch_req = 1'($urandom); fetch_addr = 10'($urandom);
        tick();
        check("gap no fetch", instr_valid, 0);
        check("gap busy", ld_busy, 1);
      end
      ld_valid = 1'b1; ld_byte = b[i]; ld_last = (i == b.size() - 1);
      fetch_req = gaps ? 1'($urandom) : 1'b0; fetch_addr = 10'($urandom);
      tick();
      mem_m[i] = b[i];
      check("load no fetch", instr_valid, 0);
      if (i < b.size() - 1) check("load done early", ld_done, 0);
    end
    check("load done", ld_done, 1);
    check("load count", ld_count, 32'(b.size()));
    check("load ready", fetch_ready, 1);
    idle_inputs();
    tick();
    check("done pulse", ld_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prog [];
    logic [7:0] rnd [];
    logic [31:0] w;

    // Reset held with random inputs.
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fetch_req = 1'($urandom); fetch_addr = 10'($urandom);
      ld_start = 1'($urandom); ld_valid = 1'($urandom);
      ld_byte = 8'($urandom); ld_last = 1'($urandom);
      tick();
    end
    check("rst valid", instr_valid, 0);
    check("rst instr", instr, 0);
    check("rst count", ld_count, 0);
    check("rst done", ld_done, 0);
    idle_inputs();
    reset = 1'b1;
    tick();
    check("rst fetch_ready", fetch_ready, 1);
    check("rst ld_busy", ld_busy, 0);

    // 8-byte program and table-driven fetches.
    prog = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
    load_bytes(prog, 1'b0);
    vecs[0] = '{10'd0, 32'h0050_0513, 1'b0};
    vecs[1] = '{10'd4, 32'h00A0_0593, 1'b0};
`ifdef INSTR_ALIGN_CHECK_EN
    vecs[2] = '{10'd2, NOP, 1'b1};
    vecs[3] = '{10'd5, NOP, 1'b1};
`else
    vecs[2] = '{10'd2, 32'h0593_0050, 1'b0};
    vecs[3] = '{10'd5, 32'h00A0_0593 >> 8 | (32'(mem_m[8]) << 24), 1'b0};
`endif
    for (int i = 0; i < 4; i++) begin
      fetch_req = 1'b1; fetch_addr = vecs[i].addr;
      tick();
      fetch_req = 1'b0;
      check($sformatf("vec%0d valid", i), instr_valid, 1);
      check($sformatf("vec%0d instr", i), instr, vecs[i].instr);
      check($sformatf("vec%0d misalign", i), instr_misalign, 32'(vecs[i].misalign));
    end
    tick();
    check("hold valid", instr_valid, 0);
    check("hold instr", instr, vecs[3].instr);

    // Back-to-back fetches 0,4,0.
    fetch_one(0, "b2b0");
    fetch_one(4, "b2b1");
    fetch_one(0, "b2b2");
    tick();
    check("b2b end", instr_valid, 0);

    // ld_start wins over fetch_req; restart while loading drops that byte.
    fetch_req = 1'b1; fetch_addr = 10'd0; ld_start = 1'b1;
    tick();
    idle_inputs();
    check("collide valid", instr_valid, 0);
    check("collide busy", ld_busy, 1);
    check("collide ready", fetch_ready, 0);
    ld_valid = 1'b1; ld_byte = 8'hAA; tick(); mem_m[0] = 8'hAA;
    ld_byte = 8'hBB; tick(); mem_m[1] = 8'hBB;
    check("pre-restart count", ld_count, 2);
    ld_start = 1'b1; ld_byte = 8'hCC; tick();
    ld_start = 1'b0;
    check("restart count", ld_count, 0);
    check("restart busy", ld_busy, 1);
    ld_byte = 8'h11; ld_last = 1'b1; tick(); mem_m[0] = 8'h11;
    check("restart done", ld_done, 1);
    check("restart final count", ld_count, 1);
    idle_inputs();
    fetch_one(0, "restart fetch");
    check("restart word", instr, 32'h0050_BB11);

    // Full 1024-byte load without ld_last.
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ld_valid = 1'b1; ld_byte = 8'(i);
      tick();
      mem_m[i] = 8'(i);
      if (i == DEPTH - 2) begin
        check("full busy", ld_busy, 1);
        check("full done early", ld_done, 0);
      end
    end
    idle_inputs();
    check("full done", ld_done, 1);
    check("full count", ld_count, 1024);
    check("full idle", fetch_ready, 1);
    fetch_one(1020, "full 1020");
    check("full 1020 const", instr, 32'hFFFE_FDFC);
    fetch_one(1022, "full 1022");
`ifdef INSTR_ALIGN_CHECK_EN
    check("full 1022 const", instr, NOP);
    check("full 1022 misalign", instr_misalign, 1);
`else
    check("full 1022 const", instr, 32'h0100_FFFE);
    check("full 1022 misalign", instr_misalign, 0);
`endif

    // Reset after 3 bytes of a load.
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_byte = 8'hDE; tick(); mem_m[0] = 8'hDE;
    ld_byte = 8'hAD; tick(); mem_m[1] = 8'hAD;
    ld_byte = 8'hBE; tick(); mem_m[2] = 8'hBE;
    idle_inputs();
    reset = 1'b0;
    #2;
    check("midrst idle", fetch_ready, 1);
    check("midrst busy", ld_busy, 0);
    check("midrst done", ld_done, 0);
    tick();
    check("midrst no done", ld_done, 0);
    reset = 1'b1;
    tick();
    fetch_one(0, "midrst fetch");
    check("midrst word", instr, 32'h03BE_ADDE);

    // Randomized loads and fetch bursts against the model.
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        rnd = new[$urandom_range(1, 16)];
        foreach (rnd[k]) rnd[k] = 8'($urandom);
        load_bytes(rnd, 1'b1);
      end
      for (int f = 0; f < int'($urandom_range(1, 6)); f++) begin
        w = $urandom_range(0, DEPTH - 1);
        if ($urandom_range(0, 1) == 0) w = w & 32'h3FC;
        fetch_one(int'(w), "rand fetch");
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
Instruction-memory responder on the fetch side of the program counter. It accepts the 10-bit fetch address and returns the 32-bit instruction stored little-endian at that byte address, one cycle later. A byte-serial loader port fills the 1024-byte store before or between runs. A two-state controller (IDLE/LOADING) arbitrates between loading and fetching.

Parameters:
ADDR_W, 10, byte-address width; store depth = 2**ADDR_W bytes
NOP_INSTR, 32'h00000013, word returned on a rejected fetch (addi x0,x0,0)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
fetch_req  in  1  fetch request, sampled on clk edge
fetch_addr  in  ADDR_W  byte address of instruction (driven by PC output)
fetch_ready  out  1  1 = fetch accepted this cycle (IDLE state)
instr_valid  out  1  1-cycle pulse: instr holds fetched word
instr  out  32  fetched instruction
instr_misalign  out  1  fetch address not word-aligned (only with ALIGN_CHECK_EN; else tied 0)
ld_start  in  1  pulse: enter LOADING, load pointer := 0
ld_valid  in  1  ld_byte valid
ld_byte  in  8  byte to store at load pointer
ld_last  in  1  qualifies the final byte with ld_valid
ld_ready  out  1  1 in LOADING
ld_busy  out  1  1 in LOADING
ld_done  out  1  1-cycle pulse when the load ends
ld_count  out  ADDR_W+1  bytes written in current/last load

Behaviour:
- Reset (reset==0, async): state=IDLE, instr_valid=0, instr=0, instr_misalign=0, ld_done=0, ld_count=0, load pointer=0. Byte store contents NOT cleared.
- fetch_ready = (state==IDLE). ld_ready = ld_busy = (state==LOADING). All three are combinational from state.
- Fetch: in IDLE, fetch_req=1 at edge N gives instr_valid=1 at edge N+1. instr = {mem[a+3],mem[a+2],mem[a+1],mem[a]}, with a=fetch_addr and the +k additions modulo 2**ADDR_W (1022 reads 1022,1023,0,1). Back-to-back fetches every cycle are allowed. instr holds its value when instr_valid=0.
- fetch_req in LOADING: ignored, instr_valid=0, no queuing.
- IDLE -> LOADING on ld_start=1. The pointer clears to 0 and ld_count clears to 0. If fetch_req=1 in the same cycle, the load wins and the fetch is dropped (instr_valid=0 next cycle).
- LOADING:
  - Each cycle with ld_valid=1, write ld_byte to mem[pointer], then pointer+1 and ld_count+1.
  - Bytes with ld_valid=0 are ignored.
  - ld_start=1 while LOADING restarts the pointer and ld_count at 0; ld_valid on that cycle is dropped.
- LOADING -> IDLE, with ld_done=1 for one cycle:
  - on ld_valid & ld_last (that byte is written), or
  - when the 1024th byte is written (ld_count reaches 1024; the pointer wraps to 0).
- First fetch is possible on the cycle after ld_done.
- Reset mid-load: returns to IDLE immediately, without ld_done. Bytes already written are kept.
- The store is written only via the loader, so no read/write collision is possible.

Optional Feature:
INSTR_ALIGN_CHECK_EN:
- Defined:
  - A fetch with fetch_addr[1:0]!=0 still yields instr_valid=1 next cycle, with instr=NOP_INSTR and instr_misalign=1.
  - Aligned fetches give instr_misalign=0.
- Undefined:
  - instr_misalign is tied 0.
  - Unaligned addresses return the 4 bytes starting at fetch_addr, with wrap.

Test Plan:
- Reset hold: reset=0 with random inputs -> instr_valid=0, instr=0, ld_count=0, fetch_ready=1 after release.
- Load 8 bytes 0x13,0x05,0x50,0x00,0x93,0x05,0xA0,0x00 (ld_last on 8th) -> ld_done pulse on edge after 8th byte, ld_count=8. Fetch addr 0 -> instr=32'h00500513 one cycle later. Fetch addr 4 -> instr=32'h00A00593.
- Back-to-back fetches at addr 0,4,0 on consecutive cycles -> instr_valid high 3 consecutive cycles with matching words.
- ld_start and fetch_req same cycle -> no instr_valid next cycle, ld_busy=1.
- Full load of 1024 bytes, value = index[7:0], no ld_last:
  - ld_done after 1024th byte, ld_count=1024.
  - Fetch addr 1020 (aligned) -> instr=32'hFFFEFDFC.
  - Fetch addr 1022 -> instr=32'h0100FFFE when macro undefined; instr=32'h00000013 and instr_misalign=1 when defined.
- Reset asserted after 3 bytes of a load -> state IDLE, no ld_done, those 3 bytes readable by a later fetch.
